// File: rtl/float_mul_arb_pkg.sv
// Shared types and constants for the float_mul arbiter slice.
package float_mul_arb_pkg;

  localparam int FLOAT_W = 32;
  localparam logic [FLOAT_W-1:0] QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/float_mul_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after rr_ptr.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!valid && req[wrap_add(rr_ptr, k)]) begin
        valid  = 1'b1;
        winner = wrap_add(rr_ptr, k);
      end
    end
  end

endmodule

// File: rtl/float_mul_arbiter.sv
// Round-robin arbiter sharing one float_mul between N_REQ requesters,
// with a watchdog that turns a hung multiply into a quiet-NaN error response.
module float_mul_arbiter
  import float_mul_arb_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 64,
  localparam int IDX_W   = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0][FLOAT_W-1:0]   req_a,
  input  logic [N_REQ-1:0][FLOAT_W-1:0]   req_b,
  output logic [N_REQ-1:0]                done,
  output logic [FLOAT_W-1:0]              result,
  output logic                            err,
  output logic                            mul_start,
  output logic [FLOAT_W-1:0]              mul_a,
  output logic [FLOAT_W-1:0]              mul_b,
  input  logic [FLOAT_W-1:0]              mul_result,
  input  logic                            mul_ready,
  output logic [IDX_W-1:0]                grant_idx,
  output logic                            busy
);

  // Handshake: a requester holds req[i] with stable operands until done[i]
  // pulses for one cycle, then drops req[i] for at least one cycle before
  // asking again. Operands are sampled only on the IDLE->ISSUE grant.
  localparam int WD_W = $clog2(TIMEOUT);

  arb_state_e       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [WD_W-1:0]  wdog;
  logic             seen_low;
  logic             err_q;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mul_a     <= '0;
      mul_b     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      wdog      <= '0;
      seen_low  <= 1'b0;
      result    <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            mul_a     <= req_a[pick_idx];
            mul_b     <= req_b[pick_idx];
            grant_idx <= pick_idx;
            rr_ptr    <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            err_q     <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          seen_low <= 1'b0;
          wdog     <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wdog <= wdog + 1'b1;
          if (!mul_ready) seen_low <= 1'b1;
          // A ready level left over from the previous multiply is ignored
          // until it has been observed low once since the start pulse.
          if (seen_low && mul_ready) begin
            result <= mul_result;
            err_q  <= 1'b0;
            state  <= ST_RESP;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            result <= QNAN;
            err_q  <= 1'b1;
            state  <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    done = '0;
    if (state == ST_RESP) done[grant_idx] = 1'b1;
  end

  assign err       = (state == ST_RESP) && err_q;
  assign mul_start = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);

endmodule
